// File: rtl/ahb_params_pkg.sv
// Shared AHB arbiter types: transfer/burst/response encodings and burst beat count.
package ahb_params_pkg;

   localparam int NO_OF_MASTERS = 4;

   typedef enum logic [1:0] {
      TR_IDLE   = 2'd0,
      TR_BUSY   = 2'd1,
      TR_NONSEQ = 2'd2,
      TR_SEQ    = 2'd3
   } htrans_e;

   typedef enum logic [2:0] {
      BU_SINGLE = 3'd0,
      BU_INCR   = 3'd1,
      BU_WRAP4  = 3'd2,
      BU_INCR4  = 3'd3,
      BU_WRAP8  = 3'd4,
      BU_INCR8  = 3'd5,
      BU_WRAP16 = 3'd6,
      BU_INCR16 = 3'd7
   } hburst_e;

   typedef enum logic [1:0] {
      RS_OKAY  = 2'd0,
      RS_ERROR = 2'd1,
      RS_RETRY = 2'd2,
      RS_SPLIT = 2'd3
   } hresp_e;

   // Undefined-length bursts count as a single beat: they never pin the grant.
   function automatic logic [4:0] beats_of(input hburst_e b);
      case (b)
         BU_WRAP4,  BU_INCR4:  beats_of = 5'd4;
         BU_WRAP8,  BU_INCR8:  beats_of = 5'd8;
         BU_WRAP16, BU_INCR16: beats_of = 5'd16;
         default:              beats_of = 5'd1;
      endcase
   endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Rotating-priority one-hot selector: first eligible index after rr_ptr, rr_ptr itself last.
module ahb_rr_picker #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] eligible_i,
   input  logic [W-1:0] rr_ptr_i,
   output logic [N-1:0] grant_o,
   output logic         valid_o
);

   logic [W-1:0] idx;

   always_comb begin
      grant_o = '0;
      valid_o = 1'b0;
      idx     = '0;
      for (int k = 1; k <= N; k++) begin
         idx = W'((int'(rr_ptr_i) + k) % N);
         if (!valid_o && eligible_i[idx]) begin
            grant_o[idx] = 1'b1;
            valid_o      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin grant with burst/lock hold and SPLIT masking.
module ahb_arbiter #(
   parameter int NO_OF_MASTERS  = ahb_params_pkg::NO_OF_MASTERS,
   parameter int DEFAULT_MASTER = 0
) (
   input  logic                             HCLK,
   input  logic                             HRESET,
   input  logic [NO_OF_MASTERS-1:0]         HBUSREQ,
   input  logic [NO_OF_MASTERS-1:0]         HLOCK,
   input  logic [NO_OF_MASTERS-1:0]         HSPLIT,
   input  logic [1:0]                       HTRANS,
   input  logic [2:0]                       HBURST,
   input  logic                             HREADY,
   input  logic [1:0]                       HRESP,
   output logic [NO_OF_MASTERS-1:0]         HGRANT,
   output logic [$clog2(NO_OF_MASTERS)-1:0] HMASTER,
   output logic                             HMASTLOCK
);
   import ahb_params_pkg::*;

   localparam int MW = $clog2(NO_OF_MASTERS);
   localparam logic [NO_OF_MASTERS-1:0] DEF_OH = NO_OF_MASTERS'(1) << DEFAULT_MASTER;

   function automatic logic [MW-1:0] oh2idx(input logic [NO_OF_MASTERS-1:0] v);
      oh2idx = '0;
      for (int i = 0; i < NO_OF_MASTERS; i++)
         if (v[i]) oh2idx = MW'(i);
   endfunction

   logic [NO_OF_MASTERS-1:0] grant_q, grant_d;
   logic [NO_OF_MASTERS-1:0] split_q, split_d;
   logic [MW-1:0]            master_q, master_d;
   logic [MW-1:0]            rr_q, rr_d;
   logic                     mlock_q, mlock_d;
   logic [3:0]               cnt_q, cnt_d;

   logic [NO_OF_MASTERS-1:0] eligible, pick_grant;
   logic                     pick_valid;
   logic [MW-1:0]            gidx;
   logic                     gvalid, hold, arb_en;

   assign gidx     = oh2idx(grant_q);
   assign gvalid   = |grant_q;
   // A lock only pins the bus while its owner is still requesting.
   assign hold     = gvalid & HLOCK[gidx] & HBUSREQ[gidx];
   assign arb_en   = HREADY & ~hold & (cnt_q <= 4'd1);
   assign eligible = HBUSREQ & ~split_q;

   ahb_rr_picker #(.N(NO_OF_MASTERS), .W(MW)) u_picker (
      .eligible_i (eligible),
      .rr_ptr_i   (rr_q),
      .grant_o    (pick_grant),
      .valid_o    (pick_valid)
   );

   always_comb begin
      grant_d  = grant_q;
      rr_d     = rr_q;
      master_d = master_q;
      mlock_d  = mlock_q;
      cnt_d    = cnt_q;
      split_d  = split_q & ~HSPLIT;

      if (arb_en) begin
         if (pick_valid)               grant_d = pick_grant;
         else if (!split_q[DEFAULT_MASTER]) grant_d = DEF_OH;
         else                          grant_d = '0;
         if (|grant_d) rr_d = oh2idx(grant_d);
      end

      if (HREADY && gvalid) begin
         master_d = gidx;
         mlock_d  = HLOCK[gidx];
      end

      if (HREADY) begin
         case (htrans_e'(HTRANS))
            TR_NONSEQ: cnt_d = 4'(beats_of(hburst_e'(HBURST)) - 5'd1);
            TR_SEQ:    if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            TR_IDLE:   cnt_d = '0;
            default:   ;
         endcase
      end
      // Any non-OKAY response aborts the burst, in either response cycle.
      if (hresp_e'(HRESP) != RS_OKAY) cnt_d = '0;

      // Set is applied after the clear so a same-cycle release loses.
      if (HREADY && hresp_e'(HRESP) == RS_SPLIT) split_d[master_q] = 1'b1;
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         grant_q  <= DEF_OH;
         rr_q     <= MW'(DEFAULT_MASTER);
         master_q <= MW'(DEFAULT_MASTER);
         mlock_q  <= 1'b0;
         cnt_q    <= '0;
         split_q  <= '0;
      end else begin
         grant_q  <= grant_d;
         rr_q     <= rr_d;
         master_q <= master_d;
         mlock_q  <= mlock_d;
         cnt_q    <= cnt_d;
         split_q  <= split_d;
      end
   end

   assign HGRANT    = grant_q;
   assign HMASTER   = master_q;
   assign HMASTLOCK = mlock_q;

endmodule
